// File: rtl/datapath_seq.sv
// rtl/datapath_seq.sv - sequenced register file, data RAM and 74381-style ALU
module datapath_seq #(
  parameter int WIDTH    = 16,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256,
  localparam int RA_W    = $clog2(RF_DEPTH),
  localparam int DA_W    = $clog2(DM_DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_alu_s,
  input  logic [RA_W-1:0]  cmd_rd,
  input  logic [RA_W-1:0]  cmd_ra,
  input  logic [RA_W-1:0]  cmd_rb,
  input  logic [DA_W-1:0]  cmd_addr,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ALU   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]       op_q;
  logic [2:0]       s_q;
  logic [RA_W-1:0]  rd_q, ra_q, rb_q;
  logic [DA_W-1:0]  addr_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] rf [RF_DEPTH];
  logic [WIDTH-1:0] mem [DM_DEPTH];
  logic [WIDTH-1:0] mem_rdata;

  logic             accept;
  logic [WIDTH:0]   sum_ab, diff_ab, diff_ba;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic [WIDTH-1:0] wb_val;
  logic             wb_en;

  // Sequencer next state, handshake and done pulse
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign wb_en  = (state == S_EXEC);

  // ALU on the latched operands; carry and borrow both come from the extra top bit
  always_comb begin
    sum_ab  = {1'b0, a_q} + {1'b0, b_q};
    diff_ab = {1'b0, a_q} - {1'b0, b_q};
    diff_ba = {1'b0, b_q} - {1'b0, a_q};
    alu_f   = '0;
    alu_c   = 1'b0;
    case (s_q)
      3'b000: alu_f = '0;
      3'b001: begin alu_f = diff_ba[WIDTH-1:0]; alu_c = diff_ba[WIDTH]; end
      3'b010: begin alu_f = diff_ab[WIDTH-1:0]; alu_c = diff_ab[WIDTH]; end
      3'b011: begin alu_f = sum_ab[WIDTH-1:0];  alu_c = sum_ab[WIDTH];  end
      3'b100: alu_f = a_q ^ b_q;
      3'b101: alu_f = a_q | b_q;
      3'b110: alu_f = a_q & b_q;
      default: alu_f = '1;
    endcase
  end

  // Value written back at the end of EXEC, selected by the command type
  always_comb begin
    wb_val = imm_q;
    case (op_q)
      OP_LOAD:  wb_val = mem_rdata;
      OP_STORE: wb_val = a_q;
      OP_ALU:   wb_val = alu_f;
      OP_LOADI: wb_val = imm_q;
      default:  wb_val = imm_q;
    endcase
  end

  // State register, command latch, operand latch, register file and status
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      s_q    <= '0;
      rd_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      addr_q <= '0;
      imm_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= cmd_op;
        s_q    <= cmd_alu_s;
        rd_q   <= cmd_rd;
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
        addr_q <= cmd_addr;
        imm_q  <= cmd_imm;
      end
      if (state == S_FETCH) begin
        a_q <= rf[ra_q];
        b_q <= rf[rb_q];
      end
      if (wb_en) begin
        result <= wb_val;
        if (op_q != OP_STORE) rf[rd_q] <= wb_val;
        if (op_q == OP_ALU) begin
          flag_z <= (alu_f == '0);
          flag_c <= alu_c;
        end
      end
    end
  end

  // Data RAM: no reset; read is registered so data issued in FETCH is valid in EXEC
  always_ff @(posedge Clk) begin
    if (wb_en && op_q == OP_STORE) mem[addr_q] <= a_q;
    mem_rdata <= mem[addr_q];
  end

endmodule
